// File: rtl/bt_status_tx.sv
// Status-frame UART transmitter: snapshots player state and sends a 7-byte 8N1 frame
// (A5, song, vol, flags, minute, second, xor checksum) on request or on state change.
`timescale 1ns/1ps
module bt_status_tx #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_song_select,
   input  logic [3:0] i_vol_level,
   input  logic       i_pause,
   input  logic       i_finish_song,
   input  logic [7:0] i_minute,
   input  logic [7:0] i_second,
   input  logic       i_send,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
   localparam logic [7:0] SyncByte = 8'hA5;

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [2:0]      byte_q, byte_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pending_q, pending_d;
   logic            finish_q, finish_d;

   logic [2:0]      song_prev_q;
   logic [3:0]      vol_prev_q;
   logic            pause_prev_q;

   logic [2:0]      snap_song_q;
   logic [3:0]      snap_vol_q;
   logic [1:0]      snap_flags_q;
   logic [7:0]      snap_min_q;
   logic [7:0]      snap_sec_q;
   logic [7:0]      snap_chk_q;

   logic            change;
   logic            req;
   logic            accept;
   logic            tc;
   logic [2:0]      next_bit;
   logic [7:0]      chk_new;
   logic [7:0]      cur_byte;

   assign change = (i_song_select != song_prev_q) | (i_vol_level != vol_prev_q) |
                   (i_pause != pause_prev_q);
   assign req    = i_send | i_finish_song | change;
   assign accept = pending_q & ((state_q == StIdle) | (state_q == StDone));
   assign tc     = (cnt_q == CntMax);
   assign next_bit = bit_q + 3'd1;

   assign chk_new = {5'b0, i_song_select} ^ {4'b0, i_vol_level} ^ {6'b0, finish_q, i_pause} ^
                    i_minute ^ i_second;

   // Requests collapse into one pending frame; a finish pulse during accept carries forward.
   assign pending_d = (pending_q & ~accept) | req;
   assign finish_d  = accept ? i_finish_song : (finish_q | i_finish_song);

   always_comb begin
      cur_byte = SyncByte;
      case (byte_q)
         3'd0:    cur_byte = SyncByte;
         3'd1:    cur_byte = {5'b0, snap_song_q};
         3'd2:    cur_byte = {4'b0, snap_vol_q};
         3'd3:    cur_byte = {6'b0, snap_flags_q};
         3'd4:    cur_byte = snap_min_q;
         3'd5:    cur_byte = snap_sec_q;
         default: cur_byte = snap_chk_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (pending_q) begin
               state_d = StStart;
               cnt_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = StIdle;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         StStart: begin
            cnt_d = cnt_q + 1'b1;
            if (tc) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = cur_byte[0];
               state_d = StData;
            end
         end
         StData: begin
            cnt_d = cnt_q + 1'b1;
            if (tc) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  bit_d = next_bit;
                  tx_d  = cur_byte[next_bit];
               end
            end
         end
         StStop: begin
            cnt_d = cnt_q + 1'b1;
            if (tc) begin
               cnt_d = '0;
               if (byte_q == 3'd6) begin
                  done_d = 1'b1;
                  // Line stays high one cycle in StDone before a back-to-back frame.
                  if (pending_q) begin
                     state_d = StDone;
                  end else begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                  end
               end else begin
                  byte_d  = byte_q + 3'd1;
                  tx_d    = 1'b0;
                  state_d = StStart;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pending_q    <= 1'b0;
         finish_q     <= 1'b0;
         song_prev_q  <= '0;
         vol_prev_q   <= '0;
         pause_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pending_q    <= pending_d;
         finish_q     <= finish_d;
         song_prev_q  <= i_song_select;
         vol_prev_q   <= i_vol_level;
         pause_prev_q <= i_pause;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_song_q  <= '0;
         snap_vol_q   <= '0;
         snap_flags_q <= '0;
         snap_min_q   <= '0;
         snap_sec_q   <= '0;
         snap_chk_q   <= '0;
      end else if (accept) begin
         snap_song_q  <= i_song_select;
         snap_vol_q   <= i_vol_level;
         snap_flags_q <= {finish_q, i_pause};
         snap_min_q   <= i_minute;
         snap_sec_q   <= i_second;
         snap_chk_q   <= chk_new;
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_bt_status_tx.sv
// Directed bench for bt_status_tx at DIV=10: captures whole frames bit-by-bit from o_tx
// and compares them against hand-computed byte sequences.
`timescale 1ns/1ps
module tb_bt_status_tx;

   localparam logic [55:0] FBase  = 56'h28_2D_03_01_05_02_A5;
   localparam logic [55:0] FVol6  = 56'h2B_2D_03_01_06_02_A5;
   localparam logic [55:0] FSong4 = 56'h2D_2D_03_01_06_04_A5;
   localparam logic [55:0] FP0    = 56'h2C_2D_03_00_06_04_A5;
   localparam logic [55:0] FFin   = 56'h2E_2D_03_02_06_04_A5;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] i_song_select;
   logic [3:0] i_vol_level;
   logic       i_pause;
   logic       i_finish_song;
   logic [7:0] i_minute;
   logic [7:0] i_second;
   logic       i_send;
   logic       o_tx;
   logic       o_busy;
   logic       o_done;

   int n_assert = 0;
   int n_fail   = 0;

   bt_status_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_song_select (i_song_select),
      .i_vol_level   (i_vol_level),
      .i_pause       (i_pause),
      .i_finish_song (i_finish_song),
      .i_minute      (i_minute),
      .i_second      (i_second),
      .i_send        (i_send),
      .o_tx          (o_tx),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for a start bit, then records 700 cycles of line and decodes 70 bit blocks.
   task automatic grab_frame(input int max_wait, output logic [55:0] frame, output bit found,
                             output bit shape_ok, output int waited, output int done_at,
                             output logic busy_end);
      logic [699:0] line;
      logic v;
      frame = '0;
      found = 1'b0;
      shape_ok = 1'b0;
      waited = 0;
      done_at = -1;
      busy_end = 1'bx;
      while (!found && waited < max_wait) begin
         @(negedge clk);
         waited++;
         if (o_tx === 1'b0) found = 1'b1;
      end
      if (!found) return;
      shape_ok = (o_busy === 1'b1);
      line[0] = o_tx;
      for (int t = 1; t <= 700; t++) begin
         @(negedge clk);
         if (t < 700) begin
            line[t] = o_tx;
            if (o_busy !== 1'b1) shape_ok = 1'b0;
         end
         if (o_done === 1'b1 && done_at < 0) done_at = t;
         if (t == 700) busy_end = o_busy;
      end
      for (int b = 0; b < 70; b++) begin
         v = line[b*10];
         for (int c = 1; c < 10; c++) if (line[b*10+c] !== v) shape_ok = 1'b0;
         if (b % 10 == 0) begin
            if (v !== 1'b0) shape_ok = 1'b0;
         end else if (b % 10 == 9) begin
            if (v !== 1'b1) shape_ok = 1'b0;
         end else begin
            frame[(b/10)*8 + (b%10) - 1] = v;
         end
      end
   endtask

   task automatic frame_check(input string tag, input logic [55:0] exp, input int exp_wait,
                              input logic exp_busy_end);
      logic [55:0] fr;
      bit found, shape_ok;
      int waited, done_at;
      logic busy_end;
      grab_frame(50, fr, found, shape_ok, waited, done_at, busy_end);
      check({tag, "_found"}, 64'(found), 64'd1);
      check({tag, "_wait"}, 64'(waited), 64'(exp_wait));
      check({tag, "_bytes"}, 64'(fr), 64'(exp));
      check({tag, "_shape"}, 64'(shape_ok), 64'd1);
      check({tag, "_done_at"}, 64'(done_at), 64'd700);
      check({tag, "_busy_end"}, 64'(busy_end), 64'(exp_busy_end));
   endtask

   task automatic no_frame(input string tag, input int cycles);
      logic [55:0] fr;
      bit found, shape_ok;
      int waited, done_at;
      logic busy_end;
      grab_frame(cycles, fr, found, shape_ok, waited, done_at, busy_end);
      check({tag, "_quiet"}, 64'(found), 64'd0);
   endtask

   task automatic send_pulse(input string tag);
      @(negedge clk);
      i_send = 1'b1;
      @(negedge clk);
      i_send = 1'b0;
      check({tag, "_pend_tx"}, 64'(o_tx), 64'd1);
      check({tag, "_pend_busy"}, 64'(o_busy), 64'd0);
   endtask

   initial begin
      int bad;
      rst = 1'b1;
      i_song_select = '0;
      i_vol_level = '0;
      i_pause = 1'b0;
      i_finish_song = 1'b0;
      i_minute = '0;
      i_second = '0;
      i_send = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_tx", 64'(o_tx), 64'd1);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      rst = 1'b0;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
      end
      check("idle_1000", 64'(bad), 64'd0);

      // Non-zero state after idle triggers an automatic frame.
      @(negedge clk);
      i_song_select = 3'd2;
      i_vol_level = 4'd5;
      i_pause = 1'b1;
      i_minute = 8'd3;
      i_second = 8'd45;
      frame_check("auto0", FBase, 2, 1'b0);
      no_frame("auto0", 100);

      send_pulse("basic");
      frame_check("basic", FBase, 1, 1'b0);
      no_frame("basic", 200);

      @(negedge clk);
      i_vol_level = 4'd6;
      frame_check("vol6", FVol6, 2, 1'b0);
      no_frame("vol6", 200);

      // Mid-frame song change plus two sends collapse into one back-to-back frame.
      send_pulse("mid");
      fork
         frame_check("mid_a", FVol6, 1, 1'b1);
         begin
            repeat (150) @(negedge clk);
            i_song_select = 3'd4;
            i_send = 1'b1;
            @(negedge clk);
            i_send = 1'b0;
            repeat (30) @(negedge clk);
            i_send = 1'b1;
            @(negedge clk);
            i_send = 1'b0;
         end
      join
      frame_check("mid_b", FSong4, 1, 1'b0);
      no_frame("mid_b", 200);

      @(negedge clk);
      i_pause = 1'b0;
      frame_check("pause0", FP0, 2, 1'b0);
      no_frame("pause0", 100);

      // Finish and send in the same cycle give a single frame with the finish flag.
      @(negedge clk);
      i_finish_song = 1'b1;
      i_send = 1'b1;
      @(negedge clk);
      i_finish_song = 1'b0;
      i_send = 1'b0;
      frame_check("finish", FFin, 1, 1'b0);
      no_frame("finish", 200);

      send_pulse("after_fin");
      frame_check("after_fin", FP0, 1, 1'b0);

      // Reset during B3 data (all-zero byte, line low).
      send_pulse("rst_mid");
      repeat (341) @(negedge clk);
      check("pre_rst_tx", 64'(o_tx), 64'd0);
      check("pre_rst_busy", 64'(o_busy), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tx", 64'(o_tx), 64'd1);
      check("async_rst_busy", 64'(o_busy), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      i_send = 1'b1;
      @(negedge clk);
      i_send = 1'b0;
      frame_check("post_rst", FP0, 1, 1'b0);
      no_frame("post_rst", 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
